// File: rtl/pcie_pipe_pkg.sv
// ---------------------------------------------------------------------------
// pcie_pipe_pkg
// Shared definitions for the PHY-side PIPE receive driver:
//   - RxStatus codes driven toward the MAC
//   - Rate encodings carried on the PIPE Rate bus
//   - receive driver state enum
//   - COM symbol used for Gen1/2 symbol alignment
//   - sync_ok(): legal 128b/130b sync header check
// ---------------------------------------------------------------------------
package pcie_pipe_pkg;

   localparam logic [2:0] RXSTAT_OK        = 3'b000;
   localparam logic [2:0] RXSTAT_DEC_ERR   = 3'b100;
   localparam logic [2:0] RXSTAT_UNDERFLOW = 3'b110;

   localparam logic [3:0] RATE_GEN1 = 4'd0;   // 2.5 GT/s
   localparam logic [3:0] RATE_GEN2 = 4'd1;   // 5 GT/s
   localparam logic [3:0] RATE_GEN3 = 4'd2;   // 8 GT/s and above

   localparam logic [7:0] COM_SYM = 8'hBC;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ALIGN,
      ST_LOCKED,
      ST_RATECHG
   } rx_state_e;

   // Only 01 and 10 are legal 128b/130b sync headers.
   function automatic logic sync_ok(input logic [1:0] sync);
      return (sync == 2'b01) || (sync == 2'b10);
   endfunction

endpackage

// File: rtl/pipe_rx_blk_framer.sv
// ---------------------------------------------------------------------------
// pipe_rx_blk_framer
// Tracks 128b/130b framing while the receive driver is locked at Gen3:
// word index within the 4-word block, a 16-block counter and the one-cycle
// gap flag raised after every 16th block.
// Ports:
//   clk_i          clock
//   rst_i          asynchronous active-high reset
//   clr_i          hold framing at block start (driver not locked)
//   acc_i          a block word was emitted this cycle
//   sob_expected_o next accepted word must be word 0 of a block
//   gap_o          current cycle is a gap cycle (no word may be accepted)
// ---------------------------------------------------------------------------
module pipe_rx_blk_framer (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic acc_i,
   output logic sob_expected_o,
   output logic gap_o
);

   logic [1:0] idx_q, idx_d;
   logic [3:0] blk_q, blk_d;
   logic       gap_q, gap_d;

   always_comb begin
      idx_d = idx_q;
      blk_d = blk_q;
      gap_d = 1'b0;
      if (clr_i) begin
         // The word that achieves lock is word 0 of block 0, so when it is
         // accepted the next expected word is index 1.
         idx_d = acc_i ? 2'd1 : 2'd0;
         blk_d = 4'd0;
      end else if (acc_i) begin
         idx_d = idx_q + 2'd1;
         if (idx_q == 2'd3) begin
            blk_d = blk_q + 4'd1;
            gap_d = (blk_q == 4'd15);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idx_q <= 2'd0;
         blk_q <= 4'd0;
         gap_q <= 1'b0;
      end else begin
         idx_q <= idx_d;
         blk_q <= blk_d;
         gap_q <= gap_d;
      end
   end

   assign sob_expected_o = (idx_q == 2'd0);
   assign gap_o          = gap_q;

endmodule

// File: rtl/pipe_phy_rx_driver.sv
// ---------------------------------------------------------------------------
// pipe_phy_rx_driver
// PHY end of the PIPE receive interface. Aligns the decoded word stream
// (COM at Gen1/2, sync header at Gen3), frames 128b/130b blocks with gap
// insertion, reports RxStatus and runs the Rate change / PhyStatus handshake.
// Configuration macro: PIPE_RX_GEN3_EN (undefined: Rate>=2 behaves as Gen2,
// no block framing, RxStartBlock/RxSyncHeader held at 0).
// Ports:
//   PCLK, reset                  clock, asynchronous active-high reset
//   Rate                         requested rate from the MAC
//   in_valid/in_ready            upstream word handshake
//   in_data/in_k/in_sob/in_sync  decoded word, K flags, block start, header
//   in_err                       decode error flag on the word
//   RxData..RxSyncHeader         registered receive word toward the MAC
//   RxValid, RxStatus, PhyStatus PIPE lock, status code, completion strobe
// ---------------------------------------------------------------------------
module pipe_phy_rx_driver #(
   parameter int RATE_CHG_CYCLES = 16
) (
   input  logic        PCLK,
   input  logic        reset,
   input  logic [3:0]  Rate,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic [3:0]  in_k,
   input  logic        in_sob,
   input  logic [1:0]  in_sync,
   input  logic        in_err,
   output logic [31:0] RxData,
   output logic [3:0]  RxDataK,
   output logic        RxDataValid,
   output logic        RxStartBlock,
   output logic [1:0]  RxSyncHeader,
   output logic        RxValid,
   output logic [2:0]  RxStatus,
   output logic        PhyStatus
);

   import pcie_pipe_pkg::*;

   localparam int          CW       = $clog2(RATE_CHG_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(RATE_CHG_CYCLES);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   rx_state_e     state_q, state_d;
   logic [3:0]    rate_q, rate_d;
   logic [3:0]    target_q, target_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [31:0]   rx_data_q, rx_data_d;
   logic [3:0]    rx_k_q, rx_k_d;
   logic          rx_dv_q, rx_dv_d;
   logic          rx_sb_q, rx_sb_d;
   logic [1:0]    rx_sh_q, rx_sh_d;
   logic          rx_valid_q, rx_valid_d;
   logic [2:0]    rx_status_q, rx_status_d;
   logic          phy_status_q, phy_status_d;

   logic          gen3;
   logic          sob_exp;
   logic          gap;
   logic          fr_acc;
   logic          fr_clr;
   logic          emit;
   logic          rate_req;

`ifdef PIPE_RX_GEN3_EN
   assign gen3 = (rate_q >= RATE_GEN3);
`else
   assign gen3 = 1'b0;
`endif

   assign fr_clr = (state_q != ST_LOCKED);

   pipe_rx_blk_framer u_framer (
      .clk_i          (PCLK),
      .rst_i          (reset),
      .clr_i          (fr_clr),
      .acc_i          (fr_acc),
      .sob_expected_o (sob_exp),
      .gap_o          (gap)
   );

   // Depends on registered state only, never on in_valid.
   always_comb begin
      in_ready = 1'b0;
      case (state_q)
         ST_ALIGN:  in_ready = 1'b1;
         ST_LOCKED: in_ready = !(gen3 && gap);
         default:   in_ready = 1'b0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      rate_d       = rate_q;
      target_d     = target_q;
      cnt_d        = cnt_q;
      rx_data_d    = '0;
      rx_k_d       = '0;
      rx_dv_d      = 1'b0;
      rx_sb_d      = 1'b0;
      rx_sh_d      = 2'b00;
      rx_valid_d   = 1'b0;
      rx_status_d  = RXSTAT_OK;
      phy_status_d = 1'b0;
      emit         = 1'b0;
      fr_acc       = 1'b0;
      rate_req     = (Rate != rate_q);

      case (state_q)
         ST_IDLE: state_d = ST_ALIGN;

         ST_ALIGN: begin
            if (rate_req) begin
               state_d  = ST_RATECHG;
               cnt_d    = CNT_LOAD;
               target_d = Rate;
            end else if (in_valid && (gen3 ? (in_sob && sync_ok(in_sync))
                                           : (in_k[0] && in_data[7:0] == COM_SYM))) begin
               state_d = ST_LOCKED;
               emit    = 1'b1;
            end
         end

         ST_LOCKED: begin
            if (rate_req) begin
               state_d  = ST_RATECHG;
               cnt_d    = CNT_LOAD;
               target_d = Rate;
            end else if (!gen3) begin
               rx_valid_d = 1'b1;
               if (in_valid) begin
                  emit = 1'b1;
               end else begin
                  // Gen1/2 underflow keeps lock; data lanes are zeroed.
                  rx_dv_d     = 1'b1;
                  rx_status_d = RXSTAT_UNDERFLOW;
               end
            end else if (gap) begin
               rx_valid_d = 1'b1;
            end else if (sob_exp) begin
               if (!in_valid) begin
                  rx_valid_d = 1'b1;           // idle between blocks
               end else if (!in_sob || !sync_ok(in_sync)) begin
                  rx_status_d = RXSTAT_DEC_ERR;
                  state_d     = ST_ALIGN;
               end else begin
                  emit = 1'b1;
               end
            end else begin
               if (!in_valid) begin
                  rx_status_d = RXSTAT_UNDERFLOW;
                  state_d     = ST_ALIGN;
               end else if (in_sob) begin
                  rx_status_d = RXSTAT_DEC_ERR;
                  state_d     = ST_ALIGN;
               end else begin
                  emit = 1'b1;
               end
            end
         end

         ST_RATECHG: begin
            // Compare against the pending rate so only a fresh change restarts.
            if (Rate != target_q) begin
               cnt_d    = CNT_LOAD;
               target_d = Rate;
            end else if (cnt_q == CNT_ONE) begin
               rate_d       = target_q;
               phy_status_d = 1'b1;
               state_d      = ST_ALIGN;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      if (emit) begin
         rx_data_d   = in_data;
         rx_k_d      = gen3 ? 4'h0 : in_k;
         rx_dv_d     = 1'b1;
         rx_sb_d     = gen3 && sob_exp;
         rx_sh_d     = (gen3 && sob_exp) ? in_sync : 2'b00;
         rx_valid_d  = 1'b1;
         rx_status_d = in_err ? RXSTAT_DEC_ERR : RXSTAT_OK;
         fr_acc      = gen3;
      end
   end

   always_ff @(posedge PCLK or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         rate_q       <= RATE_GEN1;
         target_q     <= RATE_GEN1;
         cnt_q        <= '0;
         rx_data_q    <= '0;
         rx_k_q       <= '0;
         rx_dv_q      <= 1'b0;
         rx_sb_q      <= 1'b0;
         rx_sh_q      <= 2'b00;
         rx_valid_q   <= 1'b0;
         rx_status_q  <= RXSTAT_OK;
         phy_status_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         rate_q       <= rate_d;
         target_q     <= target_d;
         cnt_q        <= cnt_d;
         rx_data_q    <= rx_data_d;
         rx_k_q       <= rx_k_d;
         rx_dv_q      <= rx_dv_d;
         rx_sb_q      <= rx_sb_d;
         rx_sh_q      <= rx_sh_d;
         rx_valid_q   <= rx_valid_d;
         rx_status_q  <= rx_status_d;
         phy_status_q <= phy_status_d;
      end
   end

   assign RxData       = rx_data_q;
   assign RxDataK      = rx_k_q;
   assign RxDataValid  = rx_dv_q;
   assign RxStartBlock = rx_sb_q;
   assign RxSyncHeader = rx_sh_q;
   assign RxValid      = rx_valid_q;
   assign RxStatus     = rx_status_q;
   assign PhyStatus    = phy_status_q;

endmodule
